// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// lc3b_pkg       : ALU operation encoding shared by decode and the stage bus.
// decode_stage_if: bus bundle for decode_stage.
//   Upstream   : in_valid, in_ready, in_instr, in_pc
//   Control    : flush (synchronous squash), stall_hazard (load-use stall)
//   Downstream : out_valid, out_ready and the decoded bundle
//                (out_pc, out_sr1/2, out_dest, out_imm, out_alu_ctrl,
//                 out_alumux2_sel, out_read, out_write, out_load_regfile,
//                 out_load_cc, out_is_branch)
//   modport slave  : the decode stage
//   modport master : the surrounding pipeline driving the stage
// -----------------------------------------------------------------------------
package lc3b_pkg;
    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;
endpackage

interface decode_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
);
    import lc3b_pkg::*;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr;
    logic [DATA_W-1:0] in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_pc;
    logic [REG_W-1:0]  out_sr1;
    logic [REG_W-1:0]  out_sr2;
    logic [REG_W-1:0]  out_dest;
    logic [DATA_W-1:0] out_imm;
    lc3b_aluop         out_alu_ctrl;
    logic [1:0]        out_alumux2_sel;
    logic              out_read;
    logic              out_write;
    logic              out_load_regfile;
    logic              out_load_cc;
    logic              out_is_branch;
    logic              stall_hazard;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_sr1, out_sr2, out_dest,
               out_imm, out_alu_ctrl, out_alumux2_sel, out_read, out_write,
               out_load_regfile, out_load_cc, out_is_branch, stall_hazard
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_sr1, out_sr2, out_dest,
               out_imm, out_alu_ctrl, out_alumux2_sel, out_read, out_write,
               out_load_regfile, out_load_cc, out_is_branch, stall_hazard
    );
endinterface

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage: registered LC-3b decode stage between IF/ID and EX.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : decode_stage_if.slave (upstream valid/ready + instr/pc,
//                downstream valid/ready + decoded bundle, flush, stall_hazard)
// Decodes one instruction per accept into a control bundle held in an output
// register, and stalls consumers of a recent LDR for LOAD_BUBBLES cycles.
// Optional: define DECODE_SHF_EN to decode SHF (1101); otherwise SHF is a NOP.
// -----------------------------------------------------------------------------
module decode_stage
    import lc3b_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int REG_W        = 3,
    parameter int LOAD_BUBBLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);

    localparam int CNT_W = (LOAD_BUBBLES > 0) ? $clog2(LOAD_BUBBLES + 1) : 1;

    // Output register occupancy; together with cnt this is the whole FSM.
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  sr1;
        logic [REG_W-1:0]  sr2;
        logic [REG_W-1:0]  dest;
        lc3b_aluop         alu;
        logic [1:0]        mux2;
        logic              read;
        logic              write;
        logic              load_regfile;
        logic              load_cc;
        logic              is_branch;
        logic              is_load;
    } bundle_t;

    logic [0:0]        state;
    bundle_t           q;
    bundle_t           dec;
    logic              uses_sr1;
    logic              uses_sr2;
    logic [CNT_W-1:0]  cnt;
    logic [REG_W-1:0]  ld_dest;
    logic              out_valid;
    logic              hazard;
    logic              rd_ld;
    logic              rd_out;
    logic              accept;
    logic [15:0]       ir;

    assign ir        = bus.in_instr[15:0];
    assign out_valid = (state == FULL);

    // ---------------------------------------------------------------- decode
    always_comb begin
        dec          = '0;
        dec.alu      = alu_pass;
        dec.pc       = bus.in_pc;
        uses_sr1     = 1'b0;
        uses_sr2     = 1'b0;
        unique case (ir[15:12])
            4'b0001, 4'b0101: begin                 // ADD / AND
                dec.dest         = ir[11:9];
                dec.sr1          = ir[8:6];
                dec.sr2          = ir[2:0];
                dec.alu          = (ir[15:12] == 4'b0001) ? alu_add : alu_and;
                dec.load_regfile = 1'b1;
                dec.load_cc      = 1'b1;
                uses_sr1         = 1'b1;
                if (ir[5]) begin
                    dec.imm  = {{(DATA_W-5){ir[4]}}, ir[4:0]};
                    dec.mux2 = 2'b11;
                end else begin
                    uses_sr2 = 1'b1;
                end
            end
            4'b1001: begin                          // NOT
                dec.dest         = ir[11:9];
                dec.sr1          = ir[8:6];
                dec.alu          = alu_not;
                dec.load_regfile = 1'b1;
                dec.load_cc      = 1'b1;
                uses_sr1         = 1'b1;
            end
            4'b0110: begin                          // LDR
                dec.dest         = ir[11:9];
                dec.sr1          = ir[8:6];
                dec.imm          = {{(DATA_W-7){ir[5]}}, ir[5:0], 1'b0};
                dec.mux2         = 2'b01;
                dec.alu          = alu_add;
                dec.read         = 1'b1;
                dec.load_regfile = 1'b1;
                dec.load_cc      = 1'b1;
                dec.is_load      = 1'b1;
                uses_sr1         = 1'b1;
            end
            4'b0111: begin                          // STR: sr2 carries store data
                dec.sr1   = ir[8:6];
                dec.sr2   = ir[11:9];
                dec.imm   = {{(DATA_W-7){ir[5]}}, ir[5:0], 1'b0};
                dec.mux2  = 2'b01;
                dec.alu   = alu_add;
                dec.write = 1'b1;
                uses_sr1  = 1'b1;
                uses_sr2  = 1'b1;
            end
            4'b0000: begin                          // BR
                dec.imm       = {{(DATA_W-10){ir[8]}}, ir[8:0], 1'b0};
                dec.mux2      = 2'b10;
                dec.alu       = alu_add;
                dec.is_branch = 1'b1;
            end
`ifdef DECODE_SHF_EN
            4'b1101: begin                          // SHF
                dec.dest         = ir[11:9];
                dec.sr1          = ir[8:6];
                dec.imm          = {{(DATA_W-4){1'b0}}, ir[3:0]};
                dec.mux2         = 2'b11;
                dec.load_regfile = 1'b1;
                dec.load_cc      = 1'b1;
                uses_sr1         = 1'b1;
                if (!ir[4])     dec.alu = alu_sll;
                else if (ir[5]) dec.alu = alu_sra;
                else            dec.alu = alu_srl;
            end
`endif
            default: ;                              // NOP bundle
        endcase
    end

    // ---------------------------------------------------------------- hazard
    // rd_out covers the LDR leaving the output register this cycle; rd_ld
    // covers the bubble window counted by cnt after the LDR was accepted.
    always_comb begin
        rd_ld  = (uses_sr1 && dec.sr1 == ld_dest) || (uses_sr2 && dec.sr2 == ld_dest);
        rd_out = (uses_sr1 && dec.sr1 == q.dest)  || (uses_sr2 && dec.sr2 == q.dest);
        hazard = (LOAD_BUBBLES != 0) &&
                 ((rd_ld && cnt != '0) ||
                  (rd_out && out_valid && q.is_load && bus.out_ready));
    end

    assign bus.in_ready     = !bus.flush && !hazard && (!out_valid || bus.out_ready);
    assign bus.stall_hazard = hazard && bus.in_valid;
    assign accept           = bus.in_valid && bus.in_ready;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            q       <= '0;
            q.alu   <= alu_pass;
            cnt     <= '0;
            ld_dest <= '0;
        end else if (bus.flush) begin
            state <= EMPTY;
            cnt   <= '0;
        end else begin
            if (accept) begin
                state <= FULL;
                q     <= dec;
            end else if (bus.out_ready) begin
                state <= EMPTY;
            end
            // cnt counts downstream-advancing cycles after an LDR enters the
            // output register, so a stalled EX does not consume bubbles.
            if (accept && dec.is_load && LOAD_BUBBLES != 0) begin
                cnt     <= CNT_W'(LOAD_BUBBLES);
                ld_dest <= dec.dest;
            end else if (bus.out_ready && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.out_valid        = out_valid;
    assign bus.out_pc           = q.pc;
    assign bus.out_sr1          = q.sr1;
    assign bus.out_sr2          = q.sr2;
    assign bus.out_dest         = q.dest;
    assign bus.out_imm          = q.imm;
    assign bus.out_alu_ctrl     = q.alu;
    assign bus.out_alumux2_sel  = q.mux2;
    assign bus.out_read         = q.read;
    assign bus.out_write        = q.write;
    assign bus.out_load_regfile = q.load_regfile;
    assign bus.out_load_cc      = q.load_cc;
    assign bus.out_is_branch    = q.is_branch;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage: directed-vector bench for decode_stage (LOAD_BUBBLES=1).
// Expected SHF behaviour follows DECODE_SHF_EN as seen by this compile.
// -----------------------------------------------------------------------------
module tb_decode_stage;
    import lc3b_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    decode_stage_if #(.DATA_W(16), .REG_W(3)) dif ();

    decode_stage #(.DATA_W(16), .REG_W(3), .LOAD_BUBBLES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] flags();
        return {27'd0, dif.out_read, dif.out_write, dif.out_load_regfile,
                dif.out_load_cc, dif.out_is_branch};
    endfunction

    // -1 in any expected field means "not defined for this opcode, skip"
    typedef struct {
        logic [15:0] ir;
        int dest, sr1, sr2, imm, alu, mux, fl;
    } vec_t;

    vec_t tv[6];

    initial begin
        // fl = {read, write, load_regfile, load_cc, is_branch}
        tv[0] = '{16'h5042,  0,  1,  2,       -1, 1,  0, 5'b00110}; // AND R0,R1,R2
        tv[1] = '{16'h967F,  3,  1, -1,       -1, 2, -1, 5'b00110}; // NOT R3,R1
        tv[2] = '{16'h7B3F, -1,  4,  5, 'hFFFE,   0,  1, 5'b01000}; // STR R5,R4,#-1
        tv[3] = '{16'h0FFF, -1, -1, -1, 'hFFFE,   0,  2, 5'b00001}; // BRnzp -1
        tv[4] = '{16'hF025, -1, -1, -1,       -1, 3, -1, 5'b00000}; // TRAP -> NOP
`ifdef DECODE_SHF_EN
        tv[5] = '{16'hD284,  1,  2, -1,   'h0004, 4,  3, 5'b00110}; // SHF LSL #4
`else
        tv[5] = '{16'hD284, -1, -1, -1,       -1, 3, -1, 5'b00000}; // SHF -> NOP
`endif

        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        dif.flush     = 1'b0;
        dif.in_valid  = 1'b0;
        dif.in_instr  = '0;
        dif.in_pc     = '0;
        dif.out_ready = 1'b1;

        // ---- reset state
        #12;
        chk("rst.out_valid", dif.out_valid, 0);
        chk("rst.stall",     dif.stall_hazard, 0);
        chk("rst.alu",       dif.out_alu_ctrl, 3);
        chk("rst.imm",       dif.out_imm, 0);
        chk("rst.pc",        dif.out_pc, 0);
        chk("rst.flags",     flags(), 0);
        rst_n = 1'b1;
        tick();

        // ---- ADD R1,R2,#-3
        dif.in_valid = 1'b1; dif.in_instr = 16'h12BD; dif.in_pc = 16'h3000;
        #1 chk("add.in_ready", dif.in_ready, 1);
        tick();
        dif.in_valid = 1'b0;
        chk("add.valid", dif.out_valid, 1);
        chk("add.dest",  dif.out_dest, 1);
        chk("add.sr1",   dif.out_sr1, 2);
        chk("add.imm",   dif.out_imm, 16'hFFFD);
        chk("add.mux2",  dif.out_alumux2_sel, 3);
        chk("add.alu",   dif.out_alu_ctrl, 0);
        chk("add.flags", flags(), 5'b00110);
        chk("add.pc",    dif.out_pc, 16'h3000);

        // ---- back-to-back decode table
        for (int i = 0; i < 6; i++) begin
            dif.in_valid = 1'b1; dif.in_instr = tv[i].ir; dif.in_pc = 16'h3010 + 16'(2*i);
            tick();
            chk($sformatf("v%0d.valid", i), dif.out_valid, 1);
            chk($sformatf("v%0d.alu", i),   dif.out_alu_ctrl, tv[i].alu);
            chk($sformatf("v%0d.flags", i), flags(), tv[i].fl);
            chk($sformatf("v%0d.pc", i),    dif.out_pc, 16'h3010 + 16'(2*i));
            if (tv[i].dest >= 0) chk($sformatf("v%0d.dest", i), dif.out_dest, tv[i].dest);
            if (tv[i].sr1  >= 0) chk($sformatf("v%0d.sr1", i),  dif.out_sr1, tv[i].sr1);
            if (tv[i].sr2  >= 0) chk($sformatf("v%0d.sr2", i),  dif.out_sr2, tv[i].sr2);
            if (tv[i].imm  >= 0) chk($sformatf("v%0d.imm", i),  dif.out_imm, tv[i].imm);
            if (tv[i].mux  >= 0) chk($sformatf("v%0d.mux2", i), dif.out_alumux2_sel, tv[i].mux);
        end
        dif.in_valid = 1'b0;
        tick();
        chk("drain.valid", dif.out_valid, 0);

        // ---- load-use: LDR R3,R4,#2 then ADD R5,R3,R3
        dif.in_valid = 1'b1; dif.in_instr = 16'h6702; dif.in_pc = 16'h3040;
        tick();
        chk("ldr.valid", dif.out_valid, 1);
        chk("ldr.imm",   dif.out_imm, 16'h0004);
        chk("ldr.read",  dif.out_read, 1);
        chk("ldr.dest",  dif.out_dest, 3);
        chk("ldr.sr1",   dif.out_sr1, 4);
        chk("ldr.mux2",  dif.out_alumux2_sel, 1);
        dif.in_instr = 16'h1AC3; dif.in_pc = 16'h3042;
        #1;
        chk("lu.stall",    dif.stall_hazard, 1);
        chk("lu.in_ready", dif.in_ready, 0);
        tick();
        chk("lu.bubble",     dif.out_valid, 0);
        chk("lu.stall_off",  dif.stall_hazard, 0);
        chk("lu.ready_back", dif.in_ready, 1);
        tick();
        chk("lu.add_valid", dif.out_valid, 1);
        chk("lu.add_dest",  dif.out_dest, 5);
        chk("lu.add_sr1",   dif.out_sr1, 3);
        chk("lu.add_sr2",   dif.out_sr2, 3);
        chk("lu.add_mux2",  dif.out_alumux2_sel, 0);

        // ---- backpressure: hold ADD R5 for 3 cycles with ADD R1 queued
        dif.out_ready = 1'b0;
        dif.in_instr = 16'h12BD; dif.in_pc = 16'h3100;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("bp%0d.in_ready", c), dif.in_ready, 0);
            tick();
            chk($sformatf("bp%0d.valid", c), dif.out_valid, 1);
            chk($sformatf("bp%0d.dest", c),  dif.out_dest, 5);
            chk($sformatf("bp%0d.pc", c),    dif.out_pc, 16'h3042);
            chk($sformatf("bp%0d.sr2", c),   dif.out_sr2, 3);
        end
        dif.out_ready = 1'b1;
        #1 chk("bp.release_ready", dif.in_ready, 1);
        tick();
        dif.in_valid = 1'b0;
        chk("bp.next_dest", dif.out_dest, 1);
        chk("bp.next_pc",   dif.out_pc, 16'h3100);
        chk("bp.next_imm",  dif.out_imm, 16'hFFFD);
        tick();

        // ---- flush with LDR held and cnt=1
        dif.in_valid = 1'b1; dif.in_instr = 16'h6702; dif.in_pc = 16'h3200;
        tick();
        chk("fl.ldr_valid", dif.out_valid, 1);
        dif.flush = 1'b1; dif.in_instr = 16'h1AC3; dif.in_pc = 16'h3202;
        #1 chk("fl.in_ready", dif.in_ready, 0);
        tick();
        dif.flush = 1'b0;
        chk("fl.valid",    dif.out_valid, 0);
        #1;
        chk("fl.no_stall", dif.stall_hazard, 0);
        chk("fl.ready",    dif.in_ready, 1);
        tick();
        dif.in_valid = 1'b0;
        chk("fl.add_valid", dif.out_valid, 1);
        chk("fl.add_pc",    dif.out_pc, 16'h3202);
        tick();

        // ---- reset pulsed mid-stall
        dif.in_valid = 1'b1; dif.in_instr = 16'h6702; dif.in_pc = 16'h3300;
        tick();
        dif.in_instr = 16'h1AC3; dif.in_pc = 16'h3302;
        #1 chk("rs.stall_before", dif.stall_hazard, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rs.valid", dif.out_valid, 0);
        chk("rs.stall", dif.stall_hazard, 0);
        #1 rst_n = 1'b1;
        #1 chk("rs.in_ready", dif.in_ready, 1);
        tick();
        dif.in_valid = 1'b0;
        chk("rs.add_valid", dif.out_valid, 1);
        chk("rs.add_dest",  dif.out_dest, 5);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

endmodule
